// File: rtl/mem_pkg.sv
// mem_pkg: shared types and decode helpers for the memory stage.
// Memory-op encodings, FSM state enum and op-class predicates used by
// mem_stage and load_align.
package mem_pkg;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LW   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LHU  = 4'd3,
        MEMOP_LB   = 4'd4,
        MEMOP_LBU  = 4'd5,
        MEMOP_SW   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SB   = 4'd8
    } memop_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Encodings 9..15 fall outside every class below and so act as NONE.
    function automatic logic is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == MEMOP_LW) || (op == MEMOP_SW);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
    endfunction

    function automatic logic is_byte(input logic [3:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_SB);
    endfunction

    // Word ops need a == 0, halfword ops need an even byte address.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        return (is_word(op) && (a != 2'b00)) || (is_half(op) && a[0]);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data lane select and sign/zero extension.
// Halfwords come from the lane pair picked by a[1]; bytes from lane a.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [3:0]  op,
    output logic [31:0] data
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Select the halfword lane pair addressed by a[1].
    always_comb begin
        if (a[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Select the byte lane addressed by a.
    always_comb begin
        case (a)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
    end

    // Extend the selected lane according to the load flavour.
    always_comb begin
        data = rdata;
        case (op)
            MEMOP_LH:  data = {{16{half_s[15]}}, half_s};
            MEMOP_LHU: data = {16'h0000, half_s};
            MEMOP_LB:  data = {{24{byte_s[7]}}, byte_s};
            MEMOP_LBU: data = {24'h000000, byte_s};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage. Registers the execute result, runs loads and
// stores over a req/ack data-memory handshake, aligns load data and hands one
// registered result per instruction to write-back.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned word and
// halfword accesses instead of issuing them.
module mem_stage
    import mem_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [31:0]   ex_aluresult,
    input  logic [3:0]    ex_memop,
    input  logic [31:0]   ex_storedata,
    input  logic [4:0]    ex_rd,
    input  logic          ex_regwrite,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic          wb_valid,
    output logic [31:0]   wb_data,
    output logic [4:0]    wb_rd,
    output logic          wb_regwrite,
    output logic          stall,
    output logic          misalign
);

    localparam logic [AW-1:0] ADDR_MASK = {{(AW-2){1'b1}}, 2'b00};

    state_t        state_r;
    state_t        state_nxt_s;

    logic          ex_ready_s;
    logic          accept_s;
    logic          mem_op_s;
    logic          trap_s;
    logic          go_wait_s;
    logic          done_s;
    logic [AW-1:0] ext_addr_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic [31:0]   load_data_s;

    // Instruction held while the access is outstanding.
    logic [31:0]   addr_r;
    logic [3:0]    op_r;
    logic [4:0]    rd_r;
    logic          regwrite_r;

    logic          dmem_req_r;
    logic          dmem_we_r;
    logic [AW-1:0] dmem_addr_r;
    logic [3:0]    dmem_be_r;
    logic [31:0]   dmem_wdata_r;

    logic          wb_valid_r;
    logic [31:0]   wb_data_r;
    logic [4:0]    wb_rd_r;
    logic          wb_regwrite_r;
    logic          misalign_r;

    assign ex_ready_s = (state_r == ST_IDLE);
    assign accept_s   = ex_valid && ex_ready_s;
    assign mem_op_s   = is_load(ex_memop) || is_store(ex_memop);
    assign done_s     = (state_r == ST_WAIT) && dmem_ack;
    assign ext_addr_s = AW'(ex_aluresult);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_s = is_misaligned(ex_memop, ex_aluresult[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    // A trapped access never enters WAIT, so it never raises dmem_req.
    assign go_wait_s = accept_s && mem_op_s && !trap_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: leave IDLE on an issued access, return on ack.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_wait_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming op.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = 32'h0000_0000;
        case (ex_memop)
            MEMOP_SW: begin
                be_s    = 4'b1111;
                wdata_s = ex_storedata;
            end
            MEMOP_SH: begin
                be_s    = ex_aluresult[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{ex_storedata[15:0]}};
            end
            MEMOP_SB: begin
                be_s    = 4'b0001 << ex_aluresult[1:0];
                wdata_s = {4{ex_storedata[7:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Data-memory request registers: loaded on issue, held through WAIT,
    // cleared when the ack completes the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= {AW{1'b0}};
            dmem_be_r    <= 4'b0000;
            dmem_wdata_r <= 32'h0000_0000;
        end else if (go_wait_s) begin
            dmem_req_r   <= 1'b1;
            dmem_we_r    <= is_store(ex_memop);
            dmem_addr_r  <= ext_addr_s & ADDR_MASK;
            dmem_be_r    <= be_s;
            dmem_wdata_r <= wdata_s;
        end else if (done_s) begin
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= {AW{1'b0}};
            dmem_be_r    <= 4'b0000;
            dmem_wdata_r <= 32'h0000_0000;
        end
    end

    // Pipeline register holding the instruction that owns the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= 32'h0000_0000;
            op_r       <= MEMOP_NONE;
            rd_r       <= 5'd0;
            regwrite_r <= 1'b0;
        end else if (go_wait_s) begin
            addr_r     <= ex_aluresult;
            op_r       <= ex_memop;
            rd_r       <= ex_rd;
            regwrite_r <= ex_regwrite;
        end
    end

    load_align u_load_align (
        .rdata (dmem_rdata),
        .a     (addr_r[1:0]),
        .op    (op_r),
        .data  (load_data_s)
    );

    // Write-back register: one-cycle wb_valid pulse per retired instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_r    <= 1'b0;
            wb_data_r     <= 32'h0000_0000;
            wb_rd_r       <= 5'd0;
            wb_regwrite_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            wb_valid_r <= 1'b0;
            misalign_r <= 1'b0;
            if (accept_s && !mem_op_s) begin
                wb_valid_r    <= 1'b1;
                wb_data_r     <= ex_aluresult;
                wb_rd_r       <= ex_rd;
                wb_regwrite_r <= ex_regwrite;
            end else if (accept_s && trap_s) begin
                wb_valid_r    <= 1'b1;
                wb_data_r     <= ex_aluresult;
                wb_rd_r       <= ex_rd;
                wb_regwrite_r <= 1'b0;
                misalign_r    <= 1'b1;
            end else if (done_s) begin
                wb_valid_r <= 1'b1;
                wb_rd_r    <= rd_r;
                if (is_store(op_r)) begin
                    wb_data_r     <= addr_r;
                    wb_regwrite_r <= 1'b0;
                end else begin
                    wb_data_r     <= load_data_s;
                    wb_regwrite_r <= regwrite_r;
                end
            end
        end
    end

    assign ex_ready    = ex_ready_s;
    assign stall       = ~ex_ready_s;
    assign dmem_req    = dmem_req_r;
    assign dmem_we     = dmem_we_r;
    assign dmem_addr   = dmem_addr_r;
    assign dmem_be     = dmem_be_r;
    assign dmem_wdata  = dmem_wdata_r;
    assign wb_valid    = wb_valid_r;
    assign wb_data     = wb_data_r;
    assign wb_rd       = wb_rd_r;
    assign wb_regwrite = wb_regwrite_r;
    assign misalign    = misalign_r;

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage of the five-stage MIPS core, directly downstream of the execute stage. It registers the execute result, issues loads and stores to data memory over a req/ack handshake, and aligns and extends load data. It stalls the pipeline while an access is outstanding and delivers one retired result per instruction to the write-back stage.

## Interface
Parameters:
- AW, 32, data-memory byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  stage can accept; high only in IDLE.
- ex_aluresult  in  32  ALU result, or effective address for memory ops.
- ex_memop  in  4  memory operation: 0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9–15 treated as NONE.
- ex_storedata  in  32  store source register value.
- ex_rd  in  5  destination register.
- ex_regwrite  in  1  instruction writes rd.
- dmem_req  out  1  access request; held until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  AW  word-aligned address, {addr[AW-1:2],2'b00}.
- dmem_be  out  4  byte enables; lane n = dmem_wdata[8n+7:8n].
- dmem_wdata  out  32  store data, lane-replicated.
- dmem_ack  in  1  access complete; rdata valid in the same cycle.
- dmem_rdata  in  32  load word.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_data  out  32  result to write back.
- wb_rd  out  5  destination register.
- wb_regwrite  out  1  write enable, qualified by wb_valid.
- stall  out  1  equals ~ex_ready.
- misalign  out  1  one-cycle misaligned-access flag (see Configuration).

## Operation
- Transfer happens when ex_valid && ex_ready at a rising edge.
- States:
  - IDLE: ex_ready=1.
  - WAIT: access outstanding, ex_ready=0.
- IDLE, transfer of a NONE op:
  - Next cycle: wb_valid=1, wb_data=ex_aluresult, wb_rd and wb_regwrite copied from the execute stage.
  - Stay in IDLE.
- IDLE, transfer of a load or store:
  - Latch address, op, store data, rd and regwrite.
  - Go to WAIT.
- WAIT:
  - dmem_req=1; dmem_we, dmem_addr, dmem_be and dmem_wdata held stable.
  - On dmem_ack, return to IDLE; next cycle wb_valid=1.
- Loads, with a = addr[1:0]:
  - LW: whole word.
  - LH/LHU: halfword from lanes {2a[1]+1, 2a[1]}, sign- or zero-extended.
  - LB/LBU: lane a, sign- or zero-extended.
  - dmem_be for loads = 4'b1111.
- Stores:
  - wb_regwrite=0; wb_data=address.
  - SW: be=1111, wdata=data.
  - SH: be=0011<<(2·a[1]), wdata={2{data[15:0]}}.
  - SB: be=0001<<a, wdata={4{data[7:0]}}.
- dmem_ack seen in IDLE is ignored.
- Idle outputs: dmem_req, dmem_we and dmem_be are 0. dmem_addr and dmem_wdata are don't-care.

## Timing
- Reset:
  - state=IDLE, so ex_ready=1 and stall=0.
  - All dmem_* outputs 0; wb_valid, wb_data, wb_rd, wb_regwrite and misalign all 0.
- NONE op latency: 1 cycle, accept edge to wb_valid.
- Memory op:
  - Accept at edge T; dmem_req high from T+1.
  - Ack in cycle T+k (k≥1; ack in the first req cycle is legal).
  - wb_valid in cycle T+k+1; next accept at edge T+k+1.
  - Minimum latency 2 cycles.
- Throughput: one NONE op per cycle back-to-back; memory ops block the stage until ack.
- Reset during WAIT: dmem_req drops at that edge and the pending instruction is discarded with no wb_valid. A late ack is ignored.
- wb_* outputs are registered; wb_valid is never high two cycles for one instruction.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned access is trapped: LW/SW with a≠0, or LH/LHU/SH with a[0]=1.
  - Such an access skips WAIT, never raises dmem_req, and produces wb_valid=1, wb_regwrite=0 and misalign=1 in the cycle after accept.
- MEM_MISALIGN_TRAP_EN undefined:
  - misalign is tied to 0.
  - LW/SW ignore a; halfword ops use a[1] only.

## Structure
- Package mem_pkg holds:
  - memop_t, the 4-bit encodings above.
  - The state enum.
  - The is_load, is_store and is_half/is_byte helper functions.
- Sub-module load_align is combinational: takes rdata, a and op, returns the extended 32-bit value.
- The FSM, pipeline register and byte-enable generation stay in mem_stage.

## Test plan
- NONE ops: aluresult 0x11, 0x22, 0x33 on consecutive cycles with rd=5,6,7 → three consecutive wb_valid pulses with matching data and rd; stall stays 0.
- LB from addr 0x1003, rdata 0x80FF_0102, ack after 3 wait cycles → wb_data=0xFFFF_FF80; stall high for 3 cycles plus the ack cycle.
- Loads from rdata 0xBEEF_1234, ack in the first req cycle:
  - LHU addr 0x2002 → 0x0000_BEEF.
  - LH addr 0x2000 → 0x0000_1234.
  - Load latency = 2.
- Stores:
  - SB addr 0x3001, data 0xAB → dmem_be=0010, dmem_wdata=0xABAB_ABAB, dmem_addr=0x3000.
  - SH addr 0x3002 → be=1100.
  - wb_regwrite=0 for both.
- Assert rst in the second WAIT cycle, then ack one cycle later → no wb_valid; ex_ready=1 after the reset edge.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x4001 → no dmem_req, misalign=1 and wb_valid=1 with wb_regwrite=0 one cycle after accept. Without the macro: same stimulus reads word 0x4000.
